// File: rtl/i2c_reg_bank.sv
// Byte-addressed register bank behind the I2C slave engine: RW config registers, an atomically
// committed wide register, a snapshot-coherent status window and sticky events with an IRQ mask.
module i2c_reg_bank #(
    parameter int                  NUM_RW     = 4,
    parameter logic [NUM_RW*8-1:0] RW_RST     = {NUM_RW{8'h00}},
    parameter logic [7:0]          RW_BASE    = 8'h18,
    parameter int                  WIDE_BYTES = 2,
    parameter logic [7:0]          WIDE_BASE  = 8'h10,
    parameter int                  RO_BYTES   = 2,
    parameter logic [7:0]          RO_BASE    = 8'h14,
    parameter int                  NUM_EVT    = 4,
    parameter logic [7:0]          EVT_ADDR   = 8'h1C
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [7:0]              addr,
    input  logic [7:0]              data_in,
    input  logic                    write_en,
    input  logic                    read_en,
    output logic [7:0]              data_out,
    output logic                    rd_valid,
    output logic [NUM_RW*8-1:0]     rw_regs,
    output logic [WIDE_BYTES*8-1:0] wide_reg,
    output logic                    wide_update,
    input  logic [RO_BYTES*8-1:0]   ro_data,
    input  logic [NUM_EVT-1:0]      evt,
    output logic                    irq,
    output logic                    addr_err
);

    localparam logic [7:0] WideLast = WIDE_BASE + 8'(WIDE_BYTES - 1);
    localparam logic [7:0] MaskAddr = EVT_ADDR + 8'd1;
    // The MSB status byte is returned live, so only the lower bytes need a snapshot.
    localparam int SnapW = (RO_BYTES > 1) ? (RO_BYTES - 1) * 8 : 8;

    logic [NUM_RW*8-1:0]         rw_q;
    logic [WIDE_BYTES*8-1:0]     wide_q;
    logic [(WIDE_BYTES-1)*8-1:0] shadow_q;
    logic [SnapW-1:0]            snap_q;
    logic [NUM_EVT-1:0]          sticky_q;
    logic [NUM_EVT-1:0]          mask_q;

    logic [7:0]         rd_byte;
    logic               hit;
    logic               ro_hit;
    logic               err_d;
    logic [NUM_EVT-1:0] clr;

    assign rw_regs  = rw_q;
    assign wide_reg = wide_q;

    always_comb begin
        rd_byte = 8'h00;
        hit     = 1'b0;
        ro_hit  = 1'b0;
        for (int k = 0; k < NUM_RW; k++) begin
            if (addr == RW_BASE + 8'(k)) begin
                hit     = 1'b1;
                rd_byte = rw_q[8*k +: 8];
            end
        end
        for (int j = 0; j < WIDE_BYTES; j++) begin
            if (addr == WIDE_BASE + 8'(j)) begin
                hit     = 1'b1;
                rd_byte = wide_q[8*(WIDE_BYTES-1-j) +: 8];
            end
        end
        if (addr == RO_BASE) begin
            hit     = 1'b1;
            ro_hit  = 1'b1;
            rd_byte = ro_data[8*(RO_BYTES-1) +: 8];
        end
        for (int j = 1; j < RO_BYTES; j++) begin
            if (addr == RO_BASE + 8'(j)) begin
                hit     = 1'b1;
                ro_hit  = 1'b1;
                rd_byte = snap_q[8*(RO_BYTES-1-j) +: 8];
            end
        end
        if (addr == EVT_ADDR) begin
            hit     = 1'b1;
            rd_byte = 8'(sticky_q);
        end
        if (addr == MaskAddr) begin
            hit     = 1'b1;
            rd_byte = 8'(mask_q);
        end
    end

    assign err_d = (read_en | write_en) & (~hit | (write_en & ro_hit));
    assign clr   = (write_en && addr == EVT_ADDR) ? data_in[NUM_EVT-1:0] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rw_q        <= RW_RST;
            wide_q      <= '0;
            shadow_q    <= '0;
            snap_q      <= '0;
            sticky_q    <= '0;
            mask_q      <= '0;
            data_out    <= 8'h00;
            rd_valid    <= 1'b0;
            wide_update <= 1'b0;
            irq         <= 1'b0;
            addr_err    <= 1'b0;
        end else begin
            rd_valid    <= read_en;
            wide_update <= 1'b0;
            addr_err    <= err_d;
            irq         <= |(sticky_q & mask_q);
            sticky_q    <= (sticky_q & ~clr) | evt;
            if (read_en) begin
                data_out <= rd_byte;
                if (addr == RO_BASE) snap_q <= ro_data[SnapW-1:0];
            end
            if (write_en) begin
                for (int k = 0; k < NUM_RW; k++) begin
                    if (addr == RW_BASE + 8'(k)) rw_q[8*k +: 8] <= data_in;
                end
                for (int j = 0; j < WIDE_BYTES - 1; j++) begin
                    if (addr == WIDE_BASE + 8'(j)) shadow_q[8*(WIDE_BYTES-2-j) +: 8] <= data_in;
                end
                if (addr == WideLast) begin
                    wide_q      <= {shadow_q, data_in};
                    wide_update <= 1'b1;
                end
                if (addr == MaskAddr) mask_q <= data_in[NUM_EVT-1:0];
            end
        end
    end

endmodule

// File: tb/tb_i2c_reg_bank.sv
// Bench for i2c_reg_bank: read data is checked against a queue of expected bytes filled as reads
// are issued; side outputs are checked directly after each access.
module tb_i2c_reg_bank;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  addr;
    logic [7:0]  data_in;
    logic        write_en;
    logic        read_en;
    logic [7:0]  data_out;
    logic        rd_valid;
    logic [31:0] rw_regs;
    logic [15:0] wide_reg;
    logic        wide_update;
    logic [15:0] ro_data;
    logic [3:0]  evt;
    logic        irq;
    logic        addr_err;

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_q[$];

    i2c_reg_bank #(
        .RW_RST(32'hA5003C01)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .addr       (addr),
        .data_in    (data_in),
        .write_en   (write_en),
        .read_en    (read_en),
        .data_out   (data_out),
        .rd_valid   (rd_valid),
        .rw_regs    (rw_regs),
        .wide_reg   (wide_reg),
        .wide_update(wide_update),
        .ro_data    (ro_data),
        .evt        (evt),
        .irq        (irq),
        .addr_err   (addr_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        addr = a; data_in = d; write_en = 1'b1;
        @(negedge clk);
        write_en = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, input logic [7:0] exp);
        addr = a; read_en = 1'b1;
        exp_q.push_back(exp);
        @(negedge clk);
        read_en = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Every rd_valid must match the oldest outstanding expected byte.
    always @(posedge clk) begin
        #1;
        if (!rst && rd_valid) begin
            if (exp_q.size() == 0) check("rd_unexpected", 32'(rd_valid), 32'd0);
            else check("rd_data", 32'(data_out), 32'(exp_q.pop_front()));
        end
    end

    initial begin
        rst = 1'b1; addr = 8'h00; data_in = 8'h00; write_en = 1'b0; read_en = 1'b0;
        ro_data = 16'h0000; evt = 4'h0;
        idle(3);
        check("rst_rw_regs", rw_regs, 32'hA5003C01);
        check("rst_data_out", 32'(data_out), 32'h0);
        check("rst_rd_valid", 32'(rd_valid), 32'h0);
        check("rst_wide_reg", 32'(wide_reg), 32'h0);
        check("rst_wide_update", 32'(wide_update), 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        check("rst_addr_err", 32'(addr_err), 32'h0);
        rst = 1'b0;
        idle(1);

        rd(8'h18, 8'h01); rd(8'h19, 8'h3C); rd(8'h1A, 8'h00); rd(8'h1B, 8'hA5);

        wr(8'h10, 8'h12);
        check("wide_no_commit_upd", 32'(wide_update), 32'h0);
        rd(8'h10, 8'h00); rd(8'h11, 8'h00);
        check("wide_partial", 32'(wide_reg), 32'h0);
        wr(8'h11, 8'h34);
        check("wide_commit", 32'(wide_reg), 32'h1234);
        check("wide_update_hi", 32'(wide_update), 32'h1);
        idle(1);
        check("wide_update_lo", 32'(wide_update), 32'h0);
        rd(8'h10, 8'h12); rd(8'h11, 8'h34);

        ro_data = 16'hABCD;
        rd(8'h14, 8'hAB);
        ro_data = 16'h0000;
        rd(8'h15, 8'hCD);
        wr(8'h14, 8'h55);
        check("ro_wr_err_hi", 32'(addr_err), 32'h1);
        idle(1);
        check("ro_wr_err_lo", 32'(addr_err), 32'h0);
        rd(8'h15, 8'hCD);

        wr(8'h1D, 8'h05);
        evt = 4'b0100;
        idle(1);
        check("irq_lag", 32'(irq), 32'h0);
        idle(1);
        check("irq_set", 32'(irq), 32'h1);
        wr(8'h1C, 8'h04);
        rd(8'h1C, 8'h04);
        evt = 4'b0000;
        wr(8'h1C, 8'h04);
        check("irq_still", 32'(irq), 32'h1);
        idle(1);
        check("irq_fall", 32'(irq), 32'h0);
        rd(8'h1C, 8'h00);
        rd(8'h1D, 8'h05);

        addr = 8'h18; data_in = 8'h77; write_en = 1'b1; read_en = 1'b1;
        exp_q.push_back(8'h01);
        @(negedge clk);
        write_en = 1'b0; read_en = 1'b0;
        check("rw0_new", 32'(rw_regs[7:0]), 32'h77);
        rd(8'h18, 8'h77);

        rd(8'h40, 8'h00);
        check("unmapped_rd_err", 32'(addr_err), 32'h1);
        wr(8'h40, 8'hFF);
        check("unmapped_wr_err", 32'(addr_err), 32'h1);
        check("unmapped_wr_rw", rw_regs, 32'hA5003C77);

        wr(8'h10, 8'h9A);
        rst = 1'b1;
        #2;
        check("mid_rst_wide", 32'(wide_reg), 32'h0);
        check("mid_rst_rw", rw_regs, 32'hA5003C01);
        check("mid_rst_data_out", 32'(data_out), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        wr(8'h11, 8'h56);
        check("post_rst_commit", 32'(wide_reg), 32'h0056);
        check("post_rst_update", 32'(wide_update), 32'h1);

        idle(2);
        check("rd_drain", 32'(exp_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
